mult_arbiter: RTL and testbench

//  Shares one registered signed 32x32 multiplier (start->done latency 2 clk, y valid with done)

---
 rtl/mult_ctrl_pkg.sv | 43 ++++
 rtl/mult_rr_arbiter.sv | 22 ++
 rtl/mult_arbiter.sv | 127 ++++++++++++
 tb/tb_mult_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared op codes, FSM states and result selection for the multiplier sequencer.
// Pure combinational helpers; no state.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_MULS_LO = 2'b00,
        OP_MULS_HI = 2'b01,
        OP_MULU_HI = 2'b10,
        OP_FIXP    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_RESP  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    localparam int unsigned MUL_LAT_DEF  = 2;
    localparam int unsigned FP_SHIFT_DEF = 16;

    // y is the signed product; the unsigned high word is recovered by adding
    // back each operand wherever the other one was negative.
    function automatic logic [31:0] sel_result(input op_e         op,
                                               input logic [63:0] y,
                                               input logic [31:0] a,
                                               input logic [31:0] b,
                                               input int unsigned fp_shift);
        logic [63:0] w_fix;
        logic [31:0] w_res;
        w_fix = y >> fp_shift;
        w_res = y[31:0];
        case (op)
            OP_MULS_LO: w_res = y[31:0];
            OP_MULS_HI: w_res = y[63:32];
            OP_MULU_HI: w_res = y[63:32] + (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
            OP_FIXP:    w_res = w_fix[31:0];
            default:    w_res = y[31:0];
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/mult_rr_arbiter.sv
// Two-way round-robin pick: contended requests go to the side not granted last.
// Combinational, zero latency; no grant when i_en is low.
module mult_rr_arbiter (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Sequences one external 2-cycle multiplier between two requesters, one op in flight.
// Accept at N, response pulse at N+3; requesters are held off (ready low) while busy or flushing.
module mult_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT  = MUL_LAT_DEF,
    parameter int unsigned FP_SHIFT = FP_SHIFT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_data,
    output logic        resp1_valid,
    output logic [31:0] resp1_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_start,
    input  logic [63:0] mul_y,
    input  logic        mul_done
);

    if (MUL_LAT < 1) begin : g_bad_lat
        $error("MUL_LAT must be at least 1");
    end

    state_e      r_state;
    logic        r_last_grant;
    logic        r_owner;
    op_e         r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_resp_data;
    logic        r_resp0_vld;
    logic        r_resp1_vld;

    logic        w_grant_en;
    logic [1:0]  w_grant;
    logic        w_gnt_any;
    logic        w_gnt_sel;
    logic [1:0]  w_op;

    // Reset also gates the grant so nothing is accepted while it is held.
    assign w_grant_en = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !flush && !reset;

    mult_rr_arbiter u_rr (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_en         (w_grant_en),
        .o_grant      (w_grant)
    );

    assign w_gnt_any  = |w_grant;
    assign w_gnt_sel  = w_grant[1];
    assign w_op       = w_gnt_sel ? req1_op : req0_op;

    assign mul_start  = w_gnt_any;
    assign mul_a      = w_gnt_sel ? req1_a : req0_a;
    assign mul_b      = w_gnt_sel ? req1_b : req0_b;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    assign resp0_valid = r_resp0_vld;
    assign resp1_valid = r_resp1_vld;
    assign resp0_data  = r_resp_data;
    assign resp1_data  = r_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op         <= OP_MULS_LO;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_resp_data  <= 32'd0;
            r_resp0_vld  <= 1'b0;
            r_resp1_vld  <= 1'b0;
        end else begin
            r_resp0_vld <= 1'b0;
            r_resp1_vld <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_gnt_any) begin
                        r_owner      <= w_gnt_sel;
                        r_last_grant <= w_gnt_sel;
                        r_op         <= op_e'(w_op);
                        r_a          <= mul_a;
                        r_b          <= mul_b;
                        r_state      <= ST_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A done coinciding with flush is already consumed, so skip DRAIN.
                    if (flush) begin
                        r_state <= mul_done ? ST_IDLE : ST_DRAIN;
                    end else if (mul_done) begin
                        r_resp_data <= sel_result(r_op, mul_y, r_a, r_b, FP_SHIFT);
                        r_resp0_vld <= !r_owner;
                        r_resp1_vld <= r_owner;
                        r_state     <= ST_RESP;
                    end
                end
                ST_DRAIN: begin
                    // Flush does not extend the drain; only the stale done ends it.
                    if (mul_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench: 2-cycle multiplier model plus a transaction-level reference for grants and results.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        rv  [2];
    logic [31:0] ra  [2];
    logic [31:0] rb  [2];
    logic [1:0]  rop [2];
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, mul_start, mul_done;
    logic [31:0] resp0_data, resp1_data, mul_a, mul_b;
    logic [63:0] mul_y;

    always #5 clk = ~clk;

    mult_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .req0_valid  (rv[0]),
        .req0_a      (ra[0]),
        .req0_b      (rb[0]),
        .req0_op     (rop[0]),
        .req0_ready  (req0_ready),
        .req1_valid  (rv[1]),
        .req1_a      (ra[1]),
        .req1_b      (rb[1]),
        .req1_op     (rop[1]),
        .req1_ready  (req1_ready),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_y       (mul_y),
        .mul_done    (mul_done)
    );

    // Registered signed multiplier, start -> done in 2 clocks, shares reset.
    logic        s1, s2;
    logic [63:0] y1, y2;
    always @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0; s2 <= 1'b0; y1 <= 64'd0; y2 <= 64'd0;
        end else begin
            s1 <= mul_start;
            y1 <= 64'($signed(mul_a)) * 64'($signed(mul_b));
            s2 <= s1;
            y2 <= y1;
        end
    end
    assign mul_done = s2;
    assign mul_y    = y2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return sp[31:0];
            2'b01:   return sp[63:32];
            2'b10:   return up[63:32];
            default: return sp[47:16];
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: at most one outstanding op, response due 3 cycles after grant.
    bit          pend = 0;
    int          pend_owner, pend_due;
    logic [31:0] pend_data;
    logic [31:0] last_resp;
    int          last_g = 1;
    bit          acc [2];
    int          g_owner_log[$];
    int          g_cyc_log[$];

    task automatic mon();
        int g, exp_g;
        if (resp0_valid || resp1_valid) begin
            check("resp_expected", pend, 1);
            check("resp_cycle", cyc, pend_due);
            check("resp_single", resp0_valid & resp1_valid, 0);
            check("resp_owner", resp1_valid, pend_owner);
            last_resp = resp1_valid ? resp1_data : resp0_data;
            check("resp_data", last_resp, pend_data);
            pend = 0;
        end else if (pend && cyc > pend_due) begin
            check("resp_timeout", cyc, pend_due);
            pend = 0;
        end
        check("start_eq_grant", mul_start, req0_ready | req1_ready);
        check("ready_onehot", req0_ready & req1_ready, 0);
        check("ready_needs_valid", (req0_ready & !rv[0]) | (req1_ready & !rv[1]), 0);
        if (req0_ready || req1_ready) begin
            g     = req1_ready ? 1 : 0;
            exp_g = (rv[0] && rv[1]) ? 1 - last_g : (rv[1] ? 1 : 0);
            check("grant_owner", g, exp_g);
            check("mul_a", mul_a, ra[g]);
            check("mul_b", mul_b, rb[g]);
            check("grant_while_busy", pend, 0);
            pend       = 1;
            pend_owner = g;
            pend_due   = cyc + 3;
            pend_data  = ref_res(rop[g], ra[g], rb[g]);
            last_g     = g;
            acc[g]     = 1;
            g_owner_log.push_back(g);
            g_cyc_log.push_back(cyc);
        end
    endtask

    task automatic tick();
        #1;
        mon();
        @(negedge clk);
    endtask

    task automatic load(input int p);
        rop[p] = 2'($urandom_range(0, 3));
        ra[p]  = rnd_opnd();
        rb[p]  = rnd_opnd();
    endtask

    task automatic do_reset();
        reset = 1; flush = 0;
        rv[0] = 0; rv[1] = 0;
        @(negedge clk);
        @(negedge clk);
        pend = 0; last_g = 1; acc[0] = 0; acc[1] = 0;
        reset = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && pend; i++) tick();
        check("drained", pend, 0);
    endtask

    task automatic single(input int p, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        rv[p] = 1; rop[p] = op; ra[p] = a; rb[p] = b;
        for (int i = 0; i < 20 && !acc[p]; i++) tick();
        check("accepted", acc[p], 1);
        rv[p] = 0; acc[p] = 0;
        drain();
        check("directed_data", last_resp, exp);
    endtask

    initial begin
        int fg;
        rv[0] = 0; rv[1] = 0;
        for (int p = 0; p < 2; p++) begin ra[p] = 0; rb[p] = 0; rop[p] = 0; end
        reset = 1; flush = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", {req0_ready, req1_ready, mul_start}, 0);
        check("rst_resp_vld", {resp0_valid, resp1_valid}, 0);
        check("rst_resp_data", {resp0_data, resp1_data}, 0);
        @(negedge clk);
        reset = 0;

        single(0, 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
        single(1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        single(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        single(0, 2'b11, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000);

        // Both requesters valid continuously from reset: strict alternation every 3 clk.
        do_reset();
        g_owner_log.delete(); g_cyc_log.delete();
        load(0); load(1); rv[0] = 1; rv[1] = 1;
        for (int i = 0; i < 40 && g_owner_log.size() < 6; i++) begin
            for (int p = 0; p < 2; p++) if (acc[p]) begin load(p); acc[p] = 0; end
            tick();
        end
        rv[0] = 0; rv[1] = 0; acc[0] = 0; acc[1] = 0;
        drain();
        check("rr_grants", g_owner_log.size(), 6);
        for (int k = 0; k < g_owner_log.size(); k++) begin
            check("rr_order", g_owner_log[k], k % 2);
            if (k > 0) check("rr_spacing", g_cyc_log[k] - g_cyc_log[k-1], 3);
        end

        // Flush the cycle after a grant: no response, next grant right after stale done.
        g_cyc_log.delete();
        load(0); rv[0] = 1;
        for (int i = 0; i < 10 && !acc[0]; i++) tick();
        check("flush_acc0", acc[0], 1);
        rv[0] = 0; acc[0] = 0;
        fg = g_cyc_log[0];
        pend = 0;
        flush = 1; load(1); rv[1] = 1;
        tick();
        flush = 0;
        tick();
        check("flush_drain_block", acc[1], 0);
        tick();
        check("flush_next_grant", acc[1], 1);
        check("flush_next_cycle", g_cyc_log[g_cyc_log.size()-1] - fg, 3);
        rv[1] = 0; acc[1] = 0;
        drain();

        // Reset while WAITing: outputs clear, no stale response, req0 wins first.
        load(1); rv[1] = 1;
        for (int i = 0; i < 10 && !acc[1]; i++) tick();
        rv[1] = 0; acc[1] = 0;
        reset = 1;
        @(negedge clk);
        #1;
        check("rstw_ready", {req0_ready, req1_ready, mul_start}, 0);
        check("rstw_resp", {resp0_valid, resp1_valid}, 0);
        check("rstw_data", resp0_data, 0);
        @(negedge clk);
        pend = 0; last_g = 1;
        reset = 0;
        load(0); load(1); rv[0] = 1; rv[1] = 1;
        tick();
        check("rstw_first_req0", acc[0], 1);
        rv[0] = 0; rv[1] = 0; acc[0] = 0; acc[1] = 0;
        drain();
        for (int i = 0; i < 4; i++) tick();

        // Random request traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) begin rv[p] = 0; acc[p] = 0; end
                if (!rv[p] && $urandom_range(0, 2) == 0) begin load(p); rv[p] = 1; end
            end
            tick();
        end
        rv[0] = 0; rv[1] = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
